// File: rtl/ripple_down_counter.sv
// Ripple (asynchronous) down counter with a clk-domain capture of the count and zero/wrap flags.
// Latency: q settles within WIDTH stage delays after posedge clk; q_sync/zero/wrap appear one clk later.
// Backpressure: none; en gates counting, and while en=0 the count and captured outputs hold.
module ripple_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_sync,
  output logic             zero,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ALL_ZERO = '0;

  // Raw ripple count. Each bit is owned by exactly one stage flop inside the
  // generate loop below; the vector only gathers them for the output and the
  // capture logic.
  logic [WIDTH-1:0] stage;

  // The ripple clock of stage i is the output of stage i-1. A stage toggles
  // when its neighbour rises 0->1, which is a borrow out of the lower bits,
  // so the chain counts down. The clk period must exceed WIDTH stage delays
  // so that the capture register below always samples a settled value.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      logic bit_q;

      // Stage 0: toggles on the system clock whenever counting is enabled.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          bit_q <= 1'b0;
        end else if (en) begin
          bit_q <= ~bit_q;
        end
      end

      assign stage[i] = bit_q;
    end else begin : g_ripple
      logic bit_q;

      // Stage i: toggles on every rising edge of the previous stage. The
      // asynchronous reset clears the whole chain at once; since every stage
      // falls (or stays) at 0, no rising edge is produced and no spurious
      // toggle happens while rstn is low.
      always_ff @(posedge stage[i-1] or negedge rstn) begin
        if (!rstn) begin
          bit_q <= 1'b0;
        end else begin
          bit_q <= ~bit_q;
        end
      end

      assign stage[i] = bit_q;
    end
  end

  assign q = stage;

  // Capture and flags: sampled at posedge clk, before the stage-0 toggle of
  // this edge can propagate, so q_sync is the settled pre-edge count and lags
  // q by one cycle. zero is derived from the same sample so it stays aligned
  // with q_sync. wrap fires for the single cycle in which q_sync moves from 0
  // to all-ones; q_sync itself serves as the previous-count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_sync <= ALL_ZERO;
      zero   <= 1'b1;
      wrap   <= 1'b0;
    end else begin
      q_sync <= stage;
      zero   <= (stage == ALL_ZERO);
      wrap   <= (stage == ALL_ONES) && (q_sync == ALL_ZERO);
    end
  end

endmodule

// File: tb/tb_ripple_down_counter.sv
// Testbench for ripple_down_counter: WIDTH=4 and WIDTH=8 instances share clk, rstn and en.
// The expected outputs come from an integer down-count model and go into a scoreboard queue.
// A monitor pops one entry after each clocked edge and compares both instances.
module tb_ripple_down_counter;

  logic       clk;
  logic       rstn;
  logic       en;
  logic [3:0] q4, qs4;
  logic       z4, w4;
  logic [7:0] q8, qs8;
  logic       z8, w8;

  ripple_down_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .en(en),
    .q(q4), .q_sync(qs4), .zero(z4), .wrap(w4)
  );

  ripple_down_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn), .en(en),
    .q(q8), .q_sync(qs8), .zero(z8), .wrap(w8)
  );

  typedef struct {
    int q4;
    int qs4;
    int z4;
    int w4;
    int q8;
    int qs8;
    int z8;
    int w8;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: the count as a plain integer and the most recent
  // captured value, for each width.
  int cnt4 = 0, cnt8 = 0;
  int cap4 = 0, cap8 = 0;
  int exp_wraps8 = 0;
  int seen_wraps8 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    cnt4 = 0;
    cnt8 = 0;
    cap4 = 0;
    cap8 = 0;
  endtask

  // Apply en for the coming posedge and push what the outputs must show after it.
  task automatic step_now(input bit e);
    exp_t x;
    en    = e;
    x.qs4 = cnt4;
    x.z4  = (cnt4 == 0);
    x.w4  = (cap4 == 0 && cnt4 == 15);
    x.q4  = e ? (cnt4 + 15) % 16 : cnt4;
    x.qs8 = cnt8;
    x.z8  = (cnt8 == 0);
    x.w8  = (cap8 == 0 && cnt8 == 255);
    x.q8  = e ? (cnt8 + 255) % 256 : cnt8;
    if (x.w8 != 0) exp_wraps8++;
    cap4 = cnt4;
    cap8 = cnt8;
    cnt4 = x.q4;
    cnt8 = x.q8;
    sb.push_back(x);
  endtask

  task automatic drive(input bit e);
    @(negedge clk);
    step_now(e);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_q4"}, q4, 0);
    chk({tag, "_qs4"}, qs4, 0);
    chk({tag, "_z4"}, z4, 1);
    chk({tag, "_w4"}, w4, 0);
    chk({tag, "_q8"}, q8, 0);
    chk({tag, "_qs8"}, qs8, 0);
    chk({tag, "_z8"}, z8, 1);
    chk({tag, "_w8"}, w8, 0);
  endtask

  // Monitor: after every posedge, compare against the oldest expectation.
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("q4", q4, x.q4);
      chk("q_sync4", qs4, x.qs4);
      chk("zero4", z4, x.z4);
      chk("wrap4", w4, x.w4);
      chk("q8", q8, x.q8);
      chk("q_sync8", qs8, x.qs8);
      chk("zero8", z8, x.z8);
      chk("wrap8", w8, x.w8);
      if (w8 === 1'b1) seen_wraps8++;
    end
  end

  // Stimulus.
  initial begin
    rstn = 1'b0;
    en   = 1'b1;
    model_reset();

    // Reset held for two cycles with en=1.
    repeat (2) begin
      @(negedge clk);
      chk_reset_state("reset");
    end

    // Synchronous release, then the full down sequence.
    @(negedge clk);
    rstn = 1'b1;
    step_now(1'b1);
    repeat (17) drive(1'b1);

    // Enable gating around q=12.
    while (cnt4 != 12) drive(1'b1);
    repeat (5) drive(1'b0);
    repeat (3) drive(1'b1);

    // Reset in the middle of a cycle at q=9.
    while (cnt4 != 9) drive(1'b1);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk_reset_state("async_reset");
    @(posedge clk);
    #1;
    chk_reset_state("held_reset");
    @(negedge clk);
    model_reset();
    rstn = 1'b1;
    step_now(1'b1);
    repeat (3) drive(1'b1);

    // Long enabled run covering full WIDTH=8 wraps, then random enable.
    repeat (260) drive(1'b1);
    repeat (200) drive(1'($urandom_range(0, 1)));

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    chk("wrap8_pulse_count", seen_wraps8, exp_wraps8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
